spi_master_ex: RTL

//  SPI master, mode 0 (CPOL=0, CPHA=0), one chip select, full duplex.

---
 rtl/spi_master_ex_pkg.sv | 18 +
 rtl/spi_master_ex_if.sv | 32 +++
 rtl/spi_master_ex_clk_div.sv | 32 +++
 rtl/spi_master_ex.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/spi_master_ex_pkg.sv
// spi_master_ex_pkg
//   Shared types and constants for the spi_master_ex SPI master slice.
//   Contents: FSM state encoding (3-bit), SPI clock polarity for mode 0.
package spi_master_ex_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_TRAIL = 3'd4,
      ST_GAP   = 3'd5
   } spi_state_t;

   // mode 0: sclk idles low, data sampled on the rising edge
   localparam logic SPI_CPOL = 1'b0;

endpackage

// File: rtl/spi_master_ex_if.sv
// spi_master_ex_if
//   Bundles the controller handshake and the SPI pins of spi_master_ex.
//   start/tx_data  : transfer request and word to send (controller -> master)
//   rx_data        : last received word (master -> controller)
//   busy/done      : transfer in progress / 1-cycle completion pulse
//   sclk/cs/mosi   : SPI outputs (cs active low, sclk idle low)
//   miso           : SPI input from the slave
//   modport master : the SPI master block
//   modport slave  : the controller/slave side that drives start, tx_data, miso
interface spi_master_ex_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  busy;
   logic                  done;
   logic                  sclk;
   logic                  cs;
   logic                  mosi;
   logic                  miso;

   modport master (
      input  start, tx_data, miso,
      output rx_data, busy, done, sclk, cs, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  rx_data, busy, done, sclk, cs, mosi
   );
endinterface

// File: rtl/spi_master_ex_clk_div.sv
// spi_master_ex_clk_div
//   Half-period timer for the SPI clock. Down-counter reloaded to CLK_DIV-1 on
//   clear or terminal count; tick is high for one clk every CLK_DIV cycles.
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   clear in  hold the timer at its reload value (start of a new phase)
//   tick  out terminal count, one half-period has elapsed
module spi_master_ex_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: rtl/spi_master_ex.sv
// spi_master_ex
//   SPI master, mode 0, single chip select, full duplex, MSB first.
//   A word is latched on an accepted start, shifted out on mosi while miso is
//   shifted in; sclk = clk / (2*CLK_DIV).
//   clk  in  system clock (posedge)
//   rst  in  asynchronous active-low reset
//   bus  master modport of spi_master_ex_if (start, tx_data, rx_data, busy,
//        done, sclk, cs, mosi, miso)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | cs high, waiting for start
//   ST_LEAD  | cs low, first bit on mosi, setup before first sclk rise
//   ST_HIGH  | sclk high, miso just captured
//   ST_LOW   | sclk low, next bit on mosi
//   ST_TRAIL | last bit done, cs hold before release
//   ST_GAP   | cs high, busy still set, minimum deselect time
module spi_master_ex
   import spi_master_ex_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2
) (
   input  logic clk,
   input  logic rst,
   spi_master_ex_if.master bus
);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   spi_state_t            state, state_nxt;
   logic [DATA_WIDTH-1:0] tx_sh, tx_sh_nxt;
   logic [DATA_WIDTH-1:0] rx_sh, rx_sh_nxt;
   logic [DATA_WIDTH-1:0] rx_q, rx_q_nxt;
   logic [BW-1:0]         bitcnt, bitcnt_nxt;
   logic                  cs_q, cs_nxt;
   logic                  sclk_q, sclk_nxt;
   logic                  mosi_q, mosi_nxt;
   logic                  busy_q, busy_nxt;
   logic                  done_q, done_nxt;
   logic                  tick;
   logic                  div_clear;
   logic                  accept;

   spi_master_ex_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .rst   (rst),
      .clear (div_clear),
      .tick  (tick)
   );

   assign div_clear = (state == ST_IDLE);

   // A start still pending when the gap expires launches the next word on
   // that same edge, so back-to-back words see exactly one gap of cs high.
   assign accept = bus.start &&
                   ((state == ST_IDLE) || ((state == ST_GAP) && tick));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         tx_sh  <= '0;
         rx_sh  <= '0;
         rx_q   <= '0;
         bitcnt <= '0;
         cs_q   <= 1'b1;
         sclk_q <= SPI_CPOL;
         mosi_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         tx_sh  <= tx_sh_nxt;
         rx_sh  <= rx_sh_nxt;
         rx_q   <= rx_q_nxt;
         bitcnt <= bitcnt_nxt;
         cs_q   <= cs_nxt;
         sclk_q <= sclk_nxt;
         mosi_q <= mosi_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tx_sh_nxt  = tx_sh;
      rx_sh_nxt  = rx_sh;
      rx_q_nxt   = rx_q;
      bitcnt_nxt = bitcnt;
      cs_nxt     = cs_q;
      sclk_nxt   = sclk_q;
      mosi_nxt   = mosi_q;
      busy_nxt   = busy_q;
      done_nxt   = 1'b0;

      case (state)
         ST_IDLE: begin
            busy_nxt = 1'b0;
         end
         ST_LEAD, ST_LOW: begin
            if (tick) begin
               sclk_nxt  = ~SPI_CPOL;
               rx_sh_nxt = {rx_sh[DATA_WIDTH-2:0], bus.miso};
               state_nxt = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (tick) begin
               sclk_nxt   = SPI_CPOL;
               bitcnt_nxt = bitcnt + 1'b1;
               if (bitcnt == LAST_BIT) begin
                  state_nxt = ST_TRAIL;
               end else begin
                  tx_sh_nxt = {tx_sh[DATA_WIDTH-2:0], 1'b0};
                  mosi_nxt  = tx_sh[DATA_WIDTH-2];
                  state_nxt = ST_LOW;
               end
            end
         end
         ST_TRAIL: begin
            if (tick) begin
               cs_nxt    = 1'b1;
               rx_q_nxt  = rx_sh;
               done_nxt  = 1'b1;
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tick) begin
               busy_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (accept) begin
         tx_sh_nxt  = bus.tx_data;
         cs_nxt     = 1'b0;
         mosi_nxt   = bus.tx_data[DATA_WIDTH-1];
         busy_nxt   = 1'b1;
         bitcnt_nxt = '0;
         state_nxt  = ST_LEAD;
      end
   end

   assign bus.rx_data = rx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.sclk    = sclk_q;
   assign bus.cs      = cs_q;
   assign bus.mosi    = mosi_q;

endmodule
